// File: rtl/vga_score_display.sv
// Multi-digit seven-segment score renderer: saturating BCD score, two-stage pixel
// pipeline with leading-zero blanking and a frame-paced blink once the score saturates.
module vga_score_display #(
  parameter int         NDIGITS      = 3,
  parameter int         XOFFSET      = 560,
  parameter int         YOFFSET      = 8,
  parameter int         SCALE        = 1,
  parameter int         LZ_BLANK     = 1,
  parameter logic [2:0] COLOR        = 3'b111,
  parameter int         BLINK_FRAMES = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   inc,
  input  logic                   clr,
  input  logic                   frame_start,
  input  logic [9:0]             col,
  input  logic [9:0]             row,
  output logic [2:0]             rgb_out,
  output logic [4*NDIGITS-1:0]   score_bcd,
  output logic                   overflow
);
  localparam int CW = $clog2(BLINK_FRAMES + 1);

  logic [4*NDIGITS-1:0] score_q, score_d;
  logic                 ovf_q, ovf_d;
  logic [CW-1:0]        bcnt_q, bcnt_d;
  logic                 phase_q, phase_d;
  logic                 all_nine, carry;

  always_comb begin
    score_d  = score_q;
    ovf_d    = ovf_q;
    all_nine = 1'b1;
    carry    = 1'b1;
    for (int i = 0; i < NDIGITS; i++)
      if (score_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
    if (clr) begin
      score_d = '0;
      ovf_d   = 1'b0;
    end else if (inc) begin
      if (all_nine) begin
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < NDIGITS; i++) begin
          if (carry) begin
            if (score_q[4*i +: 4] == 4'd9) begin
              score_d[4*i +: 4] = 4'd0;
            end else begin
              score_d[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (clr) begin
      bcnt_d  = '0;
      phase_d = 1'b1;
    end else if (ovf_q && frame_start) begin
      if (bcnt_q == CW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // Stage 1: locate the pixel in unit space and fetch the digit under it.
  logic [10:0] dx, dy, ux, uy;
  logic        in_d, in_q, blank_d, blank_q, lz;
  logic [3:0]  lx_d, lx_q, ly_d, ly_q, code_d, code_q, dg;

  always_comb begin
    dx      = {1'b0, col} - 11'(XOFFSET);
    dy      = {1'b0, row} - 11'(YOFFSET);
    ux      = dx >> SCALE;
    uy      = dy >> SCALE;
    in_d    = !dx[10] && !dy[10] && (ux < 11'(10*NDIGITS)) && (uy < 11'd13);
    ly_d    = 4'(uy);
    lx_d    = 4'd0;
    code_d  = 4'd0;
    blank_d = 1'b0;
    lz      = 1'b1;
    dg      = 4'd0;
    for (int k = 0; k < NDIGITS; k++) begin
      dg = score_q[4*(NDIGITS-1-k) +: 4];
      lz = lz && (dg == 4'd0);
      if (ux >= 11'(10*k) && ux < 11'(10*k + 10)) begin
        lx_d    = 4'(ux - 11'(10*k));
        code_d  = dg;
        blank_d = (LZ_BLANK != 0) && lz && (k < NDIGITS - 1);
      end
    end
  end

  // Stage 2: segment decode and hit test, order {A,B,C,D,E,F,G}.
  logic [6:0] seg;
  logic       mid, up, lo, lit, en;
  logic [2:0] rgb_d;

  always_comb begin
    case (code_q)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    mid = (lx_q >= 4'd1) && (lx_q <= 4'd6);
    up  = (ly_q >= 4'd1) && (ly_q <= 4'd5);
    lo  = (ly_q >= 4'd7) && (ly_q <= 4'd11);
    lit = (seg[6] && mid && ly_q == 4'd0)  ||
          (seg[5] && lx_q == 4'd7 && up)   ||
          (seg[4] && lx_q == 4'd7 && lo)   ||
          (seg[3] && mid && ly_q == 4'd12) ||
          (seg[2] && lx_q == 4'd0 && lo)   ||
          (seg[1] && lx_q == 4'd0 && up)   ||
          (seg[0] && mid && ly_q == 4'd6);
    en    = !ovf_q || phase_q;
    rgb_d = (in_q && !blank_q && lit && en) ? COLOR : 3'b000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_q <= '0;
      ovf_q   <= 1'b0;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
      in_q    <= 1'b0;
      blank_q <= 1'b0;
      lx_q    <= 4'd0;
      ly_q    <= 4'd0;
      code_q  <= 4'd0;
      rgb_out <= 3'b000;
    end else begin
      score_q <= score_d;
      ovf_q   <= ovf_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      in_q    <= in_d;
      blank_q <= blank_d;
      lx_q    <= lx_d;
      ly_q    <= ly_d;
      code_q  <= code_d;
      rgb_out <= rgb_d;
    end
  end

  assign score_bcd = score_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_vga_score_display.sv
// Self-checking bench for vga_score_display: random score/pixel stimulus against an
// arithmetic model of the digit layout, blanking and blink behaviour.
module tb_vga_score_display;
  localparam int N = 3, XOFF = 560, YOFF = 8, SC = 1, U = 2, BF = 16;

  logic        clk = 1'b0;
  logic        reset_n, inc, clr, frame_start;
  logic [9:0]  col, row;
  logic [2:0]  rgb_out;
  logic [11:0] score_bcd;
  logic        overflow;

  int tests = 0, fails = 0;
  int m_score = 0, m_ovf = 0, m_pulses = 0;
  string seg_str [10] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG",
                          "ACDFG", "ACDEFG", "ABC", "ABCDEFG", "ABCDFG"};

  always #5 clk = ~clk;

  vga_score_display #(.NDIGITS(N), .XOFFSET(XOFF), .YOFFSET(YOFF), .SCALE(SC),
                      .LZ_BLANK(1), .COLOR(3'b111), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset_n(reset_n), .inc(inc), .clr(clr), .frame_start(frame_start),
    .col(col), .row(row), .rgb_out(rgb_out), .score_bcd(score_bcd), .overflow(overflow));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int pow10(input int e);
    int p;
    p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] b;
    b = '0;
    for (int i = 0; i < N; i++) b[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return b;
  endfunction

  function automatic byte seg_at(input int lx, input int ly);
    if (lx >= 1 && lx <= 6 && ly == 0)  return "A";
    if (lx == 7 && ly >= 1 && ly <= 5)  return "B";
    if (lx == 7 && ly >= 7 && ly <= 11) return "C";
    if (lx >= 1 && lx <= 6 && ly == 12) return "D";
    if (lx == 0 && ly >= 7 && ly <= 11) return "E";
    if (lx == 0 && ly >= 1 && ly <= 5)  return "F";
    if (lx >= 1 && lx <= 6 && ly == 6)  return "G";
    return " ";
  endfunction

  function automatic bit has_seg(input int d, input byte s);
    string st;
    st = seg_str[d];
    for (int i = 0; i < st.len(); i++) if (st[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] model_rgb(input int c, input int r);
    int dx, dy, ux, ly, k, lx, p, d;
    byte s;
    dx = c - XOFF;
    dy = r - YOFF;
    if (dx < 0 || dy < 0) return 3'd0;
    ux = dx / U;
    ly = dy / U;
    k  = ux / 10;
    lx = ux % 10;
    if (k >= N || ly > 12) return 3'd0;
    p = pow10(N - 1 - k);
    if (k < N - 1 && m_score < p) return 3'd0;
    d = (m_score / p) % 10;
    s = seg_at(lx, ly);
    if (s == " " || !has_seg(d, s)) return 3'd0;
    if (m_ovf != 0 && ((m_pulses / BF) % 2) == 1) return 3'd0;
    return 3'b111;
  endfunction

  task automatic do_inc(input int n);
    for (int i = 0; i < n; i++) begin
      inc = 1'b1;
      tick();
      if (m_score == pow10(N) - 1) m_ovf = 1;
      else m_score++;
    end
    inc = 1'b0;
  endtask

  task automatic do_clr;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_score = 0; m_ovf = 0; m_pulses = 0;
  endtask

  task automatic do_frame;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (m_ovf != 0) m_pulses++;
  endtask

  task automatic check_score(input string name);
    tests++;
    if (score_bcd !== to_bcd(m_score) || overflow !== m_ovf[0]) begin
      fails++;
      $display("FAIL %s: score_bcd=%h overflow=%b, required %h / %0d",
               name, score_bcd, overflow, to_bcd(m_score), m_ovf);
    end
  endtask

  task automatic check_pixel(input int c, input int r, input string name);
    logic [2:0] e;
    col = 10'(c); row = 10'(r);
    e = model_rgb(c, r);
    tick(); tick();
    tests++;
    if (rgb_out !== e) begin
      fails++;
      $display("FAIL %s: pixel (%0d,%0d) rgb_out=%b, required %b", name, c, r, rgb_out, e);
    end
  endtask

  // Streams one pixel per clock; each result is matched two clocks after its pixel.
  task automatic scan(input int x0, input int x1, input int y0, input int y1,
                      input string name, output int lit, output int gap);
    logic [2:0] eq[$];
    int cq[$], rq[$];
    int total, bad, bx, by, cx, cy;
    logic [2:0] e, be, ba;
    total = (x1 - x0 + 1) * (y1 - y0 + 1);
    bad = 0; lit = 0; gap = 0; bx = 0; by = 0; be = 0; ba = 0;
    for (int i = 0; i <= total; i++) begin
      if (i < total) begin
        cx = x0 + i % (x1 - x0 + 1);
        cy = y0 + i / (x1 - x0 + 1);
        col = 10'(cx); row = 10'(cy);
        eq.push_back(model_rgb(cx, cy)); cq.push_back(cx); rq.push_back(cy);
      end
      tick();
      if (eq.size() == 2 || i == total) begin
        e = eq.pop_front(); cx = cq.pop_front(); cy = rq.pop_front();
        if (rgb_out !== e) begin
          if (bad == 0) begin bx = cx; by = cy; be = e; ba = rgb_out; end
          bad++;
        end
        if (rgb_out !== 3'd0) lit++;
        if (cx >= XOFF && rgb_out !== 3'd0 && ((cx - XOFF) / U) % 10 >= 8) gap++;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d mismatched pixels, required 0; first (%0d,%0d) rgb_out=%b required %b",
               name, bad, bx, by, ba, be);
    end
  endtask

  task automatic test_reset;
    int lit, gap;
    reset_n = 1'b0; inc = 0; clr = 0; frame_start = 0; col = 10'd561; row = 10'd8;
    m_score = 0; m_ovf = 0; m_pulses = 0;
    tick(); tick(); tick();
    tests++;
    if (rgb_out !== 3'd0 || score_bcd !== 12'h000 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: rgb=%b score=%h ovf=%b, required 0/000/0", rgb_out, score_bcd, overflow);
    end
    reset_n = 1'b1;
    check_score("reset_score");
    check_pixel(561, 8, "reset_digit0_blank");
    check_pixel(602, 8, "reset_digit2_segA");
    scan(560, 599, 8, 33, "reset_digits01_blank", lit, gap);
    tests++;
    if (lit != 0) begin
      fails++;
      $display("FAIL reset_lz_lit: %0d lit pixels in digits 0-1, required 0", lit);
    end
  endtask

  task automatic test_count;
    int lit, gap, tgt;
    for (int it = 0; it < 4; it++) begin
      tgt = (it == 0) ? 123 : ((it == 1) ? $urandom_range(1, 99) : $urandom_range(0, 998));
      do_clr();
      do_inc(tgt);
      check_score("count_score");
      if (it == 0) begin
        check_pixel(562, 20, "count_123_p1");
        check_pixel(572, 32, "count_123_p2");
        check_pixel(572, 8, "count_123_p3");
      end
      scan(550, 625, 4, 36, "count_scan", lit, gap);
      for (int j = 0; j < 6; j++)
        check_pixel($urandom_range(540, 640), $urandom_range(0, 45), "count_rand_pixel");
    end
  endtask

  task automatic test_segment_sweep;
    int lit, gap;
    do_clr();
    do_inc(8);
    check_score("sweep_score8");
    scan(600, 619, 8, 33, "sweep_digit2", lit, gap);
    tests++;
    if (lit != 38 * U * U) begin
      fails++;
      $display("FAIL sweep_lit_count: %0d lit pixels, required %0d", lit, 38 * U * U);
    end
    tests++;
    if (gap != 0) begin
      fails++;
      $display("FAIL sweep_gap: %0d gap pixels lit, required 0", gap);
    end
  endtask

  task automatic test_overflow;
    do_clr();
    do_inc(999);
    check_score("ovf_preload_999");
    do_inc(1);
    check_score("ovf_saturate");
    do_inc(3);
    check_score("ovf_hold");
    for (int f = 0; f < 48; f++) begin
      do_frame();
      if (f % 4 == 3 || f == 15 || f == 16 || f == 31 || f == 32)
        check_pixel(602, 8, "ovf_blink");
    end
    check_pixel(615, 20, "ovf_blink_off_segB");
    do_clr();
    check_score("ovf_clr");
    check_pixel(602, 8, "ovf_clr_phase_on");
  endtask

  task automatic test_clr_priority;
    do_clr();
    do_inc(5);
    check_score("prio_score5");
    inc = 1'b1; clr = 1'b1;
    tick();
    inc = 1'b0; clr = 1'b0;
    m_score = 0; m_ovf = 0; m_pulses = 0;
    check_score("prio_clr_wins");
    check_pixel(602, 8, "prio_phase_on");
  endtask

  task automatic test_back_to_back;
    int lit, gap;
    do_clr();
    do_inc($urandom_range(100, 900));
    check_score("b2b_score");
    scan(556, 622, 6, 34, "b2b_scan", lit, gap);
  endtask

  task automatic test_reset_midscan;
    do_clr();
    do_inc(8);
    check_pixel(602, 8, "midrst_before");
    #2;
    reset_n = 1'b0;
    #1;
    m_score = 0; m_ovf = 0; m_pulses = 0;
    tests++;
    if (rgb_out !== 3'd0 || score_bcd !== 12'h000) begin
      fails++;
      $display("FAIL midrst_async: rgb=%b score=%h, required 000/000", rgb_out, score_bcd);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    tests++;
    if (rgb_out !== 3'd0) begin
      fails++;
      $display("FAIL midrst_latency: rgb=%b one clk after release, required 000", rgb_out);
    end
    tick();
    tests++;
    if (rgb_out !== model_rgb(602, 8)) begin
      fails++;
      $display("FAIL midrst_resume: rgb=%b, required %b", rgb_out, model_rgb(602, 8));
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_segment_sweep();
    test_overflow();
    test_clr_priority();
    test_back_to_back();
    test_reset_midscan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
